// File: rtl/control_unit_if.sv
// control_unit_if
// Bundles the instruction-decode inputs, the memory handshake and every
// datapath control line between the multicycle control FSM and the datapath.
//   master : control unit side (drives controls, sees opcode/funct/mem_ready)
//   slave  : datapath side
// Parameter ALUOP_W sets the width of ALUOp.
interface control_unit_if #(
  parameter int ALUOP_W = 4
);
  logic [5:0]         opcode;
  logic [5:0]         funct;
  logic               mem_ready;
  logic               PCWrite;
  logic               PCWriteCond;
  logic               IorD;
  logic               MemRead;
  logic               MemWrite;
  logic               IRWrite;
  logic               MemtoReg;
  logic               ALUSrcA;
  logic               RegWrite;
  logic               RegDst;
  logic [1:0]         PCSource;
  logic [1:0]         ALUSrcB;
  logic [ALUOP_W-1:0] ALUOp;

  modport master (
    input  opcode, funct, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUOp
  );

  modport slave (
    output opcode, funct, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUOp
  );
endinterface

// File: rtl/control_unit.sv
// control_unit
// Multicycle CPU control FSM. Decodes opcode/funct and drives the datapath
// controls one state per cycle; memory states stall on mem_ready. Keeps a
// retired-instruction counter for bring-up.
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   bus          control_unit_if.master (opcode, funct, mem_ready, controls)
//   state        current state (debug)
//   illegal_op   trap indication
//   instr_count  retired instructions, wraps at 2^CNT_W
// Build option: define CTRL_ILLEGAL_TRAP_EN to trap unknown opcode/funct in
// HALT; otherwise unknown instructions retire as NOPs.
//
// state        | meaning
// FETCH    (0) | read instruction, PC+1 (IR/PC strobes wait on mem_ready)
// DECODE   (1) | dispatch, precompute branch target
// MEMADDR  (2) | base + sign-ext offset
// MEMREAD  (3) | load data read, waits on mem_ready
// MEMWB    (4) | load writeback
// MEMWRITE (5) | store, MemWrite strobes with mem_ready
// EXECUTE  (6) | R-type ALU op from funct
// RTYPE_WB (7) | R-type writeback to rd
// BRANCH   (8) | BEQ compare, conditional PC write
// JUMP     (9) | PC <= jump target
// IMM_EXEC(10) | ADDI / ORI ALU op
// IMM_WB  (11) | immediate writeback to rt
// HALT    (12) | illegal instruction trap (trap build only)
module control_unit #(
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  control_unit_if.master       bus,
  output logic [3:0]           state,
  output logic                 illegal_op,
  output logic [CNT_W-1:0]     instr_count
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADDR  = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_RTYPE_WB = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_IMM_EXEC = 4'd10,
    S_IMM_WB   = 4'd11,
    S_HALT     = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] ALU_XOR = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(5);

  function automatic logic funct_legal(input logic [5:0] f);
    return (f == 6'b100000) || (f == 6'b100010) || (f == 6'b100100) ||
           (f == 6'b100101) || (f == 6'b100110) || (f == 6'b101010);
  endfunction

  function automatic logic [ALUOP_W-1:0] alu_from_funct(input logic [5:0] f);
    case (f)
      6'b100010: return ALU_SUB;
      6'b100100: return ALU_AND;
      6'b100101: return ALU_OR;
      6'b100110: return ALU_XOR;
      6'b101010: return ALU_SLT;
      default:   return ALU_ADD;
    endcase
  endfunction

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  // Low for the first cycle after reset so FETCH controls appear one cycle later.
  logic               active_q;
  // Moore controls are registered from the next state; the mem_ready-gated
  // strobes keep only their enable in a flop.
  logic               fetch_q, fetch_d;
  logic               mem_write_en_q, mem_write_en_d;
  logic               pc_write_q, pc_write_d;
  logic               pc_write_cond_q, pc_write_cond_d;
  logic               iord_q, iord_d;
  logic               mem_read_q, mem_read_d;
  logic               mem_to_reg_q, mem_to_reg_d;
  logic               alu_src_a_q, alu_src_a_d;
  logic               reg_write_q, reg_write_d;
  logic               reg_dst_q, reg_dst_d;
  logic [1:0]         pc_source_q, pc_source_d;
  logic [1:0]         alu_src_b_q, alu_src_b_d;
  logic [ALUOP_W-1:0] alu_op_q, alu_op_d;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic               illegal_q, illegal_d;
`endif

  always_comb begin
    logic retire;
    logic bad_instr;
    state_d   = state_q;
    retire    = 1'b0;
    bad_instr = 1'b0;
    if (active_q) begin
      case (state_q)
        S_FETCH:    if (bus.mem_ready) state_d = S_DECODE;
        S_DECODE: begin
          case (bus.opcode)
            OP_LW, OP_SW:    state_d = S_MEMADDR;
            OP_RTYPE: begin
              if (funct_legal(bus.funct)) state_d = S_EXECUTE;
              else                        bad_instr = 1'b1;
            end
            OP_BEQ:          state_d = S_BRANCH;
            OP_J:            state_d = S_JUMP;
            OP_ADDI, OP_ORI: state_d = S_IMM_EXEC;
            default:         bad_instr = 1'b1;
          endcase
          if (bad_instr) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            state_d = S_HALT;
`else
            state_d = S_FETCH;
            retire  = 1'b1;
`endif
          end
        end
        S_MEMADDR:  state_d = (bus.opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:  if (bus.mem_ready) state_d = S_MEMWB;
        S_MEMWRITE: begin
          if (bus.mem_ready) begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end
        end
        S_EXECUTE:  state_d = S_RTYPE_WB;
        S_IMM_EXEC: state_d = S_IMM_WB;
        S_MEMWB, S_RTYPE_WB, S_BRANCH, S_JUMP, S_IMM_WB: begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
`ifdef CTRL_ILLEGAL_TRAP_EN
        S_HALT:     state_d = S_HALT;
`endif
        default:    state_d = S_FETCH;
      endcase
    end else begin
      state_d = S_FETCH;
    end

    cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;

    fetch_d         = 1'b0;
    mem_write_en_d  = 1'b0;
    pc_write_d      = 1'b0;
    pc_write_cond_d = 1'b0;
    iord_d          = 1'b0;
    mem_read_d      = 1'b0;
    mem_to_reg_d    = 1'b0;
    alu_src_a_d     = 1'b0;
    reg_write_d     = 1'b0;
    reg_dst_d       = 1'b0;
    pc_source_d     = 2'b00;
    alu_src_b_d     = 2'b00;
    alu_op_d        = ALU_ADD;
`ifdef CTRL_ILLEGAL_TRAP_EN
    illegal_d       = 1'b0;
`endif
    case (state_d)
      S_FETCH: begin
        fetch_d     = 1'b1;
        mem_read_d  = 1'b1;
        alu_src_b_d = 2'b01;
      end
      S_DECODE:   alu_src_b_d = 2'b10;
      S_MEMADDR: begin
        alu_src_a_d = 1'b1;
        alu_src_b_d = 2'b10;
      end
      S_MEMREAD: begin
        mem_read_d = 1'b1;
        iord_d     = 1'b1;
      end
      S_MEMWB: begin
        reg_write_d  = 1'b1;
        mem_to_reg_d = 1'b1;
      end
      S_MEMWRITE: begin
        mem_write_en_d = 1'b1;
        iord_d         = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a_d = 1'b1;
        alu_op_d    = alu_from_funct(bus.funct);
      end
      S_RTYPE_WB: begin
        reg_write_d = 1'b1;
        reg_dst_d   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_d     = 1'b1;
        alu_op_d        = ALU_SUB;
        pc_write_cond_d = 1'b1;
        pc_source_d     = 2'b01;
      end
      S_JUMP: begin
        pc_write_d  = 1'b1;
        pc_source_d = 2'b10;
      end
      S_IMM_EXEC: begin
        alu_src_a_d = 1'b1;
        if (bus.opcode == OP_ORI) begin
          alu_src_b_d = 2'b11;
          alu_op_d    = ALU_OR;
        end else begin
          alu_src_b_d = 2'b10;
        end
      end
      S_IMM_WB:   reg_write_d = 1'b1;
`ifdef CTRL_ILLEGAL_TRAP_EN
      S_HALT:     illegal_d = 1'b1;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= S_FETCH;
      cnt_q           <= '0;
      active_q        <= 1'b0;
      fetch_q         <= 1'b0;
      mem_write_en_q  <= 1'b0;
      pc_write_q      <= 1'b0;
      pc_write_cond_q <= 1'b0;
      iord_q          <= 1'b0;
      mem_read_q      <= 1'b0;
      mem_to_reg_q    <= 1'b0;
      alu_src_a_q     <= 1'b0;
      reg_write_q     <= 1'b0;
      reg_dst_q       <= 1'b0;
      pc_source_q     <= 2'b00;
      alu_src_b_q     <= 2'b00;
      alu_op_q        <= '0;
`ifdef CTRL_ILLEGAL_TRAP_EN
      illegal_q       <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      active_q        <= 1'b1;
      fetch_q         <= fetch_d;
      mem_write_en_q  <= mem_write_en_d;
      pc_write_q      <= pc_write_d;
      pc_write_cond_q <= pc_write_cond_d;
      iord_q          <= iord_d;
      mem_read_q      <= mem_read_d;
      mem_to_reg_q    <= mem_to_reg_d;
      alu_src_a_q     <= alu_src_a_d;
      reg_write_q     <= reg_write_d;
      reg_dst_q       <= reg_dst_d;
      pc_source_q     <= pc_source_d;
      alu_src_b_q     <= alu_src_b_d;
      alu_op_q        <= alu_op_d;
`ifdef CTRL_ILLEGAL_TRAP_EN
      illegal_q       <= illegal_d;
`endif
    end
  end

  // Side-effect strobes are held off during mem_ready wait cycles.
  assign bus.PCWrite     = pc_write_q | (fetch_q & bus.mem_ready);
  assign bus.IRWrite     = fetch_q & bus.mem_ready;
  assign bus.MemWrite    = mem_write_en_q & bus.mem_ready;
  assign bus.PCWriteCond = pc_write_cond_q;
  assign bus.IorD        = iord_q;
  assign bus.MemRead     = mem_read_q;
  assign bus.MemtoReg    = mem_to_reg_q;
  assign bus.ALUSrcA     = alu_src_a_q;
  assign bus.RegWrite    = reg_write_q;
  assign bus.RegDst      = reg_dst_q;
  assign bus.PCSource    = pc_source_q;
  assign bus.ALUSrcB     = alu_src_b_q;
  assign bus.ALUOp       = alu_op_q;

  assign state       = state_q;
  assign instr_count = cnt_q;
`ifdef CTRL_ILLEGAL_TRAP_EN
  assign illegal_op  = illegal_q;
`else
  assign illegal_op  = 1'b0;
`endif

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  state;
  logic        illegal_op;
  logic [31:0] instr_count;

  control_unit_if #(.ALUOP_W(4)) bus ();

  control_unit #(.ALUOP_W(4), .CNT_W(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .state       (state),
    .illegal_op  (illegal_op),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_J = 6'b000010,
                         OP_ADDI = 6'b001000, OP_ORI = 6'b001101;

  typedef struct packed {
    logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, srca, rw, rdst;
    logic [1:0] pcsrc, srcb;
    logic [3:0] aluop;
  } ctrl_t;

  typedef struct {
    logic [3:0]  st;
    ctrl_t       c;
    logic        ill;
    logic [31:0] cnt;
  } exp_t;

  typedef struct {
    logic       mr;
    logic [5:0] opc;
    logic [5:0] fn;
  } stim_t;

  exp_t        exp_q[$];
  stim_t       stim_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_count = 0;
  logic [5:0]  cur_opc = 0;
  logic [5:0]  cur_fn = 0;

  function automatic ctrl_t obs_ctrl();
    ctrl_t c;
    c.pcw = bus.PCWrite;   c.pcwc = bus.PCWriteCond; c.iord = bus.IorD;
    c.mrd = bus.MemRead;   c.mwr = bus.MemWrite;     c.irw = bus.IRWrite;
    c.m2r = bus.MemtoReg;  c.srca = bus.ALUSrcA;     c.rw = bus.RegWrite;
    c.rdst = bus.RegDst;   c.pcsrc = bus.PCSource;   c.srcb = bus.ALUSrcB;
    c.aluop = bus.ALUOp;
    return c;
  endfunction

  function automatic logic [3:0] funct_alu(input logic [5:0] fn);
    case (fn)
      6'b100010: return 4'd1;
      6'b100100: return 4'd2;
      6'b100101: return 4'd3;
      6'b100110: return 4'd4;
      6'b101010: return 4'd5;
      default:   return 4'd0;
    endcase
  endfunction

  // Expected control word per state, straight from the state table.
  function automatic ctrl_t exp_ctrl(input int s, input logic [5:0] opc,
                                     input logic [5:0] fn, input logic mr);
    ctrl_t c = '0;
    case (s)
      0:  begin c.mrd = 1; c.srcb = 2'b01; c.irw = mr; c.pcw = mr; end
      1:  c.srcb = 2'b10;
      2:  begin c.srca = 1; c.srcb = 2'b10; end
      3:  begin c.mrd = 1; c.iord = 1; end
      4:  begin c.rw = 1; c.m2r = 1; end
      5:  begin c.mwr = mr; c.iord = 1; end
      6:  begin c.srca = 1; c.aluop = funct_alu(fn); end
      7:  begin c.rw = 1; c.rdst = 1; end
      8:  begin c.srca = 1; c.aluop = 4'd1; c.pcwc = 1; c.pcsrc = 2'b01; end
      9:  begin c.pcw = 1; c.pcsrc = 2'b10; end
      10: begin
        c.srca = 1;
        if (opc == OP_ORI) begin c.srcb = 2'b11; c.aluop = 4'd3; end
        else c.srcb = 2'b10;
      end
      11: c.rw = 1;
      default: c = '0;
    endcase
    return c;
  endfunction

  task automatic set_instr(input logic [5:0] opc, input logic [5:0] fn);
    cur_opc = opc;
    cur_fn  = fn;
  endtask

  task automatic plan(input int s, input logic mr);
    exp_t  e;
    stim_t d;
    e.st  = s[3:0];
    e.c   = exp_ctrl(s, cur_opc, cur_fn, mr);
    e.ill = (s == 12);
    e.cnt = exp_count;
    exp_q.push_back(e);
    d.mr = mr; d.opc = cur_opc; d.fn = cur_fn;
    stim_q.push_back(d);
  endtask

  task automatic retire();
    exp_count = exp_count + 1;
  endtask

  task automatic run_planned(input string name);
    exp_t  e;
    stim_t d;
    ctrl_t o;
    int    cyc = 0;
    while (stim_q.size() > 0) begin
      @(negedge clk);
      d = stim_q.pop_front();
      bus.mem_ready = d.mr;
      bus.opcode    = d.opc;
      bus.funct     = d.fn;
      #1;
      e = exp_q.pop_front();
      o = obs_ctrl();
      checks++;
      if (state !== e.st || o !== e.c || illegal_op !== e.ill || instr_count !== e.cnt) begin
        failures++;
        $display("FAIL %s cycle %0d: got state=%0d ctrl=%h ill=%b cnt=%0d, want state=%0d ctrl=%h ill=%b cnt=%0d",
                 name, cyc, state, o, illegal_op, instr_count, e.st, e.c, e.ill, e.cnt);
      end
      cyc++;
    end
  endtask

  task automatic check_zero(input string name);
    ctrl_t o;
    o = obs_ctrl();
    checks++;
    if (state !== 4'd0 || o !== ctrl_t'(0) || illegal_op !== 1'b0 || instr_count !== 32'd0) begin
      failures++;
      $display("FAIL %s: got state=%0d ctrl=%h ill=%b cnt=%0d, want all zero",
               name, state, o, illegal_op, instr_count);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.mem_ready = 1'b1;
    bus.opcode = OP_LW;
    bus.funct  = 6'd0;
    exp_count  = 0;
    repeat (2) begin
      @(negedge clk);
      #1;
      check_zero("reset_held");
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_zero("reset_release");
  endtask

  task automatic test_lw();
    set_instr(OP_LW, 6'd0);
    plan(0, 1); plan(1, 1); plan(2, 1); plan(3, 1); plan(4, 1);
    retire();
    run_planned("lw");
  endtask

  task automatic test_rtype_sub();
    set_instr(OP_R, 6'b100010);
    plan(0, 1); plan(1, 1); plan(6, 1); plan(7, 1);
    retire();
    run_planned("rtype_sub");
  endtask

  task automatic test_sw_stall();
    set_instr(OP_SW, 6'd0);
    plan(0, 1); plan(1, 1); plan(2, 1);
    plan(5, 0); plan(5, 0); plan(5, 0); plan(5, 1);
    retire();
    run_planned("sw_stall");
  endtask

  task automatic test_beq_j();
    set_instr(OP_BEQ, 6'd0);
    plan(0, 1); plan(1, 1); plan(8, 1);
    retire();
    set_instr(OP_J, 6'd0);
    plan(0, 1); plan(1, 1); plan(9, 1);
    retire();
    run_planned("beq_j");
  endtask

  task automatic test_stalls();
    set_instr(OP_ORI, 6'd0);
    plan(0, 0); plan(0, 0); plan(0, 1); plan(1, 1); plan(10, 1); plan(11, 1);
    retire();
    set_instr(OP_LW, 6'd0);
    plan(0, 1); plan(1, 1); plan(2, 1); plan(3, 0); plan(3, 0); plan(3, 1); plan(4, 1);
    retire();
    run_planned("fetch_memread_stall");
  endtask

  task automatic test_back_to_back();
    logic [5:0] fl [0:4];
    fl = '{6'b100000, 6'b100100, 6'b100101, 6'b100110, 6'b101010};
    for (int i = 0; i < 5; i++) begin
      set_instr(OP_R, fl[i]);
      plan(0, 1); plan(1, 1); plan(6, 1); plan(7, 1);
      retire();
    end
    set_instr(OP_ADDI, 6'b101010);
    plan(0, 1); plan(1, 1); plan(10, 1); plan(11, 1);
    retire();
    set_instr(OP_SW, 6'd0);
    plan(0, 1); plan(1, 1); plan(2, 1); plan(5, 1);
    retire();
    run_planned("back_to_back");
  endtask

  task automatic test_illegal();
    set_instr(6'b111111, 6'd0);
    plan(0, 1); plan(1, 1);
`ifdef CTRL_ILLEGAL_TRAP_EN
    for (int i = 0; i < 10; i++) plan(12, 1);
`else
    retire();
    plan(0, 0);
    set_instr(OP_R, 6'b111111);
    plan(0, 1); plan(1, 1);
    retire();
    plan(0, 0);
`endif
    run_planned("illegal");
  endtask

  task automatic test_reset_mid();
    set_instr(OP_R, 6'b100000);
    plan(0, 1); plan(1, 1); plan(6, 1); plan(7, 1);
    retire();
    set_instr(OP_LW, 6'd0);
    plan(0, 1); plan(1, 1); plan(2, 1); plan(3, 0);
    run_planned("reset_mid_pre");
    reset = 1'b0;
    #1;
    check_zero("reset_mid_abort");
    @(negedge clk);
    #1;
    check_zero("reset_mid_held");
    reset = 1'b1;
    exp_count = 0;
  endtask

  initial begin
    bus.mem_ready = 1'b0;
    bus.opcode    = 6'd0;
    bus.funct     = 6'd0;
    #1;
    test_reset();
    test_lw();
    test_rtype_sub();
    test_sw_stall();
    test_beq_j();
    test_stalls();
    test_back_to_back();
    test_illegal();
    test_reset();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
